// File: rtl/main_mem_burst_if.sv
// rtl/main_mem_burst_if.sv - request/ACK bus between a requester and main_mem_burst
// MEM_ERR is present only when MEM_ADDR_CHECK_EN is defined.
interface main_mem_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    request;
  logic                    MEM_WE;
  logic                    burst;
  logic [ADDR_WIDTH-1:0]   addressBus;
  logic [DATA_WIDTH-1:0]   wrData;
  logic [DATA_WIDTH/8-1:0] byteEn;
  logic [DATA_WIDTH-1:0]   rdData;
  logic                    MEM_ACK;
  logic                    MEM_DONE;
  logic                    MEM_BUSY;
`ifdef MEM_ADDR_CHECK_EN
  logic                    MEM_ERR;
`endif

  modport master (
    output request, MEM_WE, burst, addressBus, wrData, byteEn,
`ifdef MEM_ADDR_CHECK_EN
    input  MEM_ERR,
`endif
    input  rdData, MEM_ACK, MEM_DONE, MEM_BUSY
  );

  modport slave (
    input  request, MEM_WE, burst, addressBus, wrData, byteEn,
`ifdef MEM_ADDR_CHECK_EN
    output MEM_ERR,
`endif
    output rdData, MEM_ACK, MEM_DONE, MEM_BUSY
  );
endinterface

// File: rtl/main_mem_burst.sv
// rtl/main_mem_burst.sv - clocked main memory with programmable latency and wrapping bursts
// Optional address checking (MEM_ERR) is enabled by defining MEM_ADDR_CHECK_EN.
module main_mem_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int BURST_LEN  = 4,
  parameter int LATENCY    = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  main_mem_burst_if.slave bus
);
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(NBYTES);
  localparam int BL_LOG2  = $clog2(BURST_LEN);
  localparam int CNT_W    = $clog2(LATENCY + 1);
  localparam logic [DEPTH_LOG2-1:0] WRAP_MASK = DEPTH_LOG2'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] idx_inc;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [BL_LOG2-1:0]    beat;
  logic                  we_q;
  logic                  burst_q;
  logic                  err_q;
  logic                  err_in;
  logic                  last_beat;
  logic                  rd_we;
  logic                  rd_err;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  ack;
  logic                  done;
  logic                  busy;
  logic                  unused_addr;

  assign addr_word   = bus.addressBus >> OFF_BITS;
  assign idx_in      = addr_word[DEPTH_LOG2-1:0];
  assign unused_addr = ^addr_word;

  // Critical-word-first: only the in-block bits advance, so the burst wraps inside its line.
  assign idx_inc   = (idx & ~WRAP_MASK) | ((idx + DEPTH_LOG2'(1)) & WRAP_MASK);
  assign last_beat = !burst_q || (beat == BL_LOG2'(BURST_LEN - 1));

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);
  assign err_in = ((bus.addressBus & OFF_MASK) != '0) || ((addr_word >> DEPTH_LOG2) != '0);
`else
  assign err_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.request) state_nxt = (LATENCY == 1) ? XFER : WAIT;
      WAIT: if (cnt == CNT_W'(1)) state_nxt = XFER;
      XFER: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == XFER);
    done = (state == XFER) && last_beat;
    busy = (state != IDLE);
  end

  assign bus.MEM_ACK  = ack;
  assign bus.MEM_DONE = done;
  assign bus.MEM_BUSY = busy;
  assign bus.rdData   = rd_q;
`ifdef MEM_ADDR_CHECK_EN
  assign bus.MEM_ERR  = ack && err_q;
`endif

  // rdData is loaded on the edge that enters each ACK cycle, so the index and
  // attributes come from the bus while still accepting and from the latches afterwards.
  always_comb begin
    rd_idx = idx_inc;
    rd_we  = we_q;
    rd_err = err_q;
    if (state == IDLE) begin
      rd_idx = idx_in;
      rd_we  = bus.MEM_WE;
      rd_err = err_in;
    end else if (state == WAIT) begin
      rd_idx = idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      idx     <= '0;
      beat    <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.request) begin
          idx     <= idx_in;
          we_q    <= bus.MEM_WE;
          burst_q <= bus.burst;
          err_q   <= err_in;
          cnt     <= CNT_W'(LATENCY - 1);
          beat    <= '0;
        end
        WAIT: cnt <= cnt - CNT_W'(1);
        XFER: begin
          idx  <= idx_inc;
          beat <= beat + BL_LOG2'(1);
        end
        default: ;
      endcase
      if (state_nxt == XFER && !rd_we) rd_q <= rd_err ? '0 : mem[rd_idx];
    end
  end

  // No reset here: contents survive reset, and a reset forces IDLE which stops writes at once.
  always_ff @(posedge clk) begin
    if (state == XFER && we_q && !err_q) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.byteEn[b]) mem[idx][b*8 +: 8] <= bus.wrData[b*8 +: 8];
      end
    end
  end
endmodule

// File: doc/main_mem_burst.md
Name: main_mem_burst

Overview:
- Synchronous, clocked main-memory model; parametrised successor of the asynchronous single-word request/ACK memory.
- Serves the L1 cache and the paging walker. Supports single-word and wrapping burst (cache-line) transfers, byte-enabled writes, and a programmable access latency.
- Uses split read/write data buses instead of a tristate bus.

Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- ADDR_WIDTH, 32: byte-address width.
- DEPTH_LOG2, 14: log2 of word count (16384 words).
- BURST_LEN, 4: beats per burst; power of 2, at least 2.
- LATENCY, 3: cycles from the accept edge to the first ACK; at least 1.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- request, input, 1: transaction request; sampled only in IDLE.
- MEM_WE, input, 1: 0 = read, 1 = write; latched at accept.
- burst, input, 1: 0 = single beat, 1 = BURST_LEN beats; latched at accept.
- addressBus, input, ADDR_WIDTH: byte address; latched at accept.
- wrData, input, DATA_WIDTH: write data for the current beat.
- byteEn, input, DATA_WIDTH/8: per-byte write enable for the current beat.
- rdData, output, DATA_WIDTH: read data; valid in cycles where MEM_ACK is high.
- MEM_ACK, output, 1: one pulse per beat.
- MEM_DONE, output, 1: pulse coincident with the last beat's ACK.
- MEM_BUSY, output, 1: high from the cycle after accept through the last-ACK cycle.

Behaviour:
- Reset: asynchronous assert, synchronous-safe deassert. Forces state IDLE and rdData, MEM_ACK, MEM_DONE, MEM_BUSY (and MEM_ERR) to 0.
- Memory contents: zero at time 0; not cleared by reset.
- Reset mid-transaction: abort immediately. Beats already written persist; no further ACKs.
- Word index: addressBus >> log2(DATA_WIDTH/8), low DEPTH_LOG2 bits. Higher bits alias and byte-offset bits are ignored (except under the optional feature).
- FSM states:
  - IDLE: request=1 at an edge accepts the transaction. Latch address, MEM_WE and burst; load latency counter = LATENCY-1; go to WAIT. If LATENCY=1, go straight to XFER.
  - WAIT: decrement the counter; at 0 go to XFER.
  - XFER: MEM_ACK=1 every cycle, one beat per cycle, no gaps.
    - Read: rdData = memory at the current index in the same cycle (registered on entry).
    - Write: wrData/byteEn are sampled at the edge ending the ACK cycle. Only enabled bytes update.
    - Next index: increment the low log2(BURST_LEN) bits only, wrapping within the aligned block (critical-word-first). Upper bits are unchanged.
    - Last beat (beat 0 if single, beat BURST_LEN-1 if burst): assert MEM_DONE with that ACK; return to IDLE.
- First ACK is exactly LATENCY cycles after the accept edge. MEM_DONE is LATENCY+BURST_LEN-1 cycles after accept for a burst.
- request while BUSY is ignored and not queued. If request is still high in IDLE after DONE, the next transaction is accepted, giving at minimum one idle cycle between transactions.
- rdData holds its last value outside ACK cycles and is not updated by writes.
- byteEn=0 on a write beat still ACKs; memory is unchanged.
- MEM_WE or address changes after accept have no effect.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - Adds output MEM_ERR (1 bit).
  - At accept, MEM_ERR is set if address bits above the DEPTH_LOG2 word range are non-zero, or if the byte-offset bits are non-zero.
  - An errored transaction still runs the full timing and ACK/DONE sequence. Writes are suppressed and rdData = 0.
  - MEM_ERR is high with every ACK of that transaction and 0 otherwise.
- Undefined: no MEM_ERR port; addresses alias silently.

Test Plan:
- Reset then single read: accept at edge N with addr 0x100 → ACK and DONE at cycle N+3 with rdData=0; BUSY high for cycles N+1..N+3.
- Single write then read: write 0xDEADBEEF, byteEn=4'hF, to 0x2000; then write 0x000000AA, byteEn=4'h1, to 0x2000; read 0x2000 → 0xDEADBEAA.
- Wrapping burst read:
  - Preload words at 0x3000/04/08/0C = 1, 2, 3, 4.
  - Burst read at 0x3008 → ACK on 4 consecutive cycles with rdData 3, 4, 1, 2; DONE on the 4th.
- Burst write then LATENCY=1 variant: burst write 0xA0..0xA3 at 0x4000 → words stored in order. With LATENCY=1, the first ACK arrives on the cycle after accept.
- request toggled while BUSY and reset_n pulsed mid-burst:
  - No extra transaction from the BUSY toggles.
  - After reset: all outputs 0 immediately; beats already written are retained and later beats are not.
- MEM_ADDR_CHECK_EN: read 0x00010000 (DEPTH_LOG2=14) → MEM_ERR=1 with ACK, rdData=0. Write to 0x2002 → MEM_ERR=1 and memory unchanged.
